// File: rtl/lane_pkg.sv
// Shared types and helpers for the lane unpacker.
package lane_pkg;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned LANE_SUM_W = LANE_W + 2;
  localparam int unsigned LANES      = 4;

  typedef logic [LANE_W-1:0] lane_t;

  // Collection state equals the number of beats already held for the current word.
  typedef enum logic [1:0] {
    StCollect0 = 2'd0,
    StCollect1 = 2'd1,
    StCollect2 = 2'd2,
    StCollect3 = 2'd3
  } col_state_e;

  // Widen a lane to the sum width, sign- or zero-extending by the lane's attribute.
  function automatic logic [LANE_SUM_W-1:0] ext_lane(lane_t v, bit is_signed);
    return {{(LANE_SUM_W - LANE_W){is_signed & v[LANE_W-1]}}, v};
  endfunction

endpackage

// File: rtl/lane_sum.sv
// Combinational adder tree over four lanes, each widened per its signedness bit.
module lane_sum
  import lane_pkg::*;
#(
  parameter int unsigned WIDTH       = LANE_W,
  parameter int unsigned SUM_W       = WIDTH + 2,
  parameter logic [3:0]  SIGNED_MASK = 4'b1110
) (
  input  logic [WIDTH-1:0]        lane_a,
  input  logic [WIDTH-1:0]        lane_b,
  input  logic [WIDTH-1:0]        lane_c,
  input  logic [WIDTH-1:0]        lane_d,
  output logic signed [SUM_W-1:0] sum
);

  logic [WIDTH-1:0] lanes [LANES];
  logic [SUM_W-1:0] ext   [LANES];

  assign lanes[0] = lane_a;
  assign lanes[1] = lane_b;
  assign lanes[2] = lane_c;
  assign lanes[3] = lane_d;

  // Extend every lane to SUM_W, then add as a balanced tree (wraps modulo 2^SUM_W).
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ext[i] = {{(SUM_W - WIDTH){SIGNED_MASK[i] & lanes[i][WIDTH-1]}}, lanes[i]};
    end
    sum = (ext[0] + ext[1]) + (ext[2] + ext[3]);
  end

endmodule

// File: rtl/lane_unpacker.sv
// Collects four byte beats into lanes a..d and presents them, with their
// signedness-aware sum, behind a valid/ready output register.
module lane_unpacker
  import lane_pkg::*;
#(
  parameter int unsigned WIDTH       = LANE_W,
  parameter logic [3:0]  SIGNED_MASK = 4'b1110,
  parameter int unsigned SUM_W       = WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_abort,
  output logic [WIDTH-1:0]        out_a,
  output logic signed [WIDTH-1:0] out_b,
  output logic signed [WIDTH-1:0] out_c,
  output logic signed [WIDTH-1:0] out_d,
  output logic signed [SUM_W-1:0] out_sum,
  output logic                    out_valid,
  input  logic                    out_ready
);

  col_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;
  logic [WIDTH-1:0] hold_c_q, hold_c_d;
  logic             valid_d;
  logic             accept;
  logic             load_word;
  logic [SUM_W-1:0] sum_next;

  // Backpressure only when a word is waiting and the consumer is not taking it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  lane_sum #(
    .WIDTH       (WIDTH),
    .SUM_W       (SUM_W),
    .SIGNED_MASK (SIGNED_MASK)
  ) u_lane_sum (
    .lane_a (hold_a_q),
    .lane_b (hold_b_q),
    .lane_c (hold_c_q),
    .lane_d (in_data),
    .sum    (sum_next)
  );

  // Next-state for the collection FSM and holding lanes; abort wins over a beat.
  always_comb begin
    state_d   = state_q;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    hold_c_d  = hold_c_q;
    load_word = 1'b0;
    if (in_abort) begin
      state_d  = StCollect0;
      hold_a_d = '0;
      hold_b_d = '0;
      hold_c_d = '0;
    end else if (accept) begin
      unique case (state_q)
        StCollect0: begin
          hold_a_d = in_data;
          state_d  = StCollect1;
        end
        StCollect1: begin
          hold_b_d = in_data;
          state_d  = StCollect2;
        end
        StCollect2: begin
          hold_c_d = in_data;
          state_d  = StCollect3;
        end
        StCollect3: begin
          load_word = 1'b1;
          state_d   = StCollect0;
        end
        default: state_d = StCollect0;
      endcase
    end
  end

  // A completing beat refills the output even while the old word is taken.
  always_comb begin
    valid_d = out_valid;
    if (load_word) begin
      valid_d = 1'b1;
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Collection state and holding lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StCollect0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      hold_c_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      hold_c_q <= hold_c_d;
    end
  end

  // Output word register; data only changes when a new word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_d     <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_d;
      if (load_word) begin
        out_a   <= hold_a_q;
        out_b   <= hold_b_q;
        out_c   <= hold_c_q;
        out_d   <= in_data;
        out_sum <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_lane_unpacker.sv
// Randomized and directed checks of lane_unpacker against a beat-queue model.
// Two instances share stimulus: default mask (1110) and all-unsigned (0000).
module tb_lane_unpacker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_abort;
  logic       out_ready;

  logic       s_in_ready, u_in_ready;
  logic [7:0] s_a, s_b, s_c, s_d, u_a, u_b, u_c, u_d;
  logic [9:0] s_sum, u_sum;
  logic       s_valid, u_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         beats[$];
  int         m_lane[4];
  bit         m_valid;
  logic [9:0] m_sum_s, m_sum_u;

  always #5 clk = ~clk;

  lane_unpacker dut_s (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid),
    .in_ready (s_in_ready), .in_abort (in_abort),
    .out_a (s_a), .out_b (s_b), .out_c (s_c), .out_d (s_d),
    .out_sum (s_sum), .out_valid (s_valid), .out_ready (out_ready)
  );

  lane_unpacker #(.SIGNED_MASK (4'b0000)) dut_u (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid),
    .in_ready (u_in_ready), .in_abort (in_abort),
    .out_a (u_a), .out_b (u_b), .out_c (u_c), .out_d (u_d),
    .out_sum (u_sum), .out_valid (u_valid), .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_value(input int b, input bit sgn);
    return (sgn && b >= 128) ? b - 256 : b;
  endfunction

  function automatic logic [9:0] ref_sum(input logic [3:0] mask);
    int s = 0;
    for (int i = 0; i < 4; i++) s += lane_value(m_lane[i], mask[i]);
    return s[9:0];
  endfunction

  task automatic model_reset();
    beats.delete();
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_lane[i] = 0;
    m_sum_s = '0;
    m_sum_u = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, s_valid}, {31'd0, m_valid});
    check("out_a", {24'd0, s_a}, m_lane[0]);
    check("out_b", {24'd0, s_b}, m_lane[1]);
    check("out_c", {24'd0, s_c}, m_lane[2]);
    check("out_d", {24'd0, s_d}, m_lane[3]);
    check("out_sum", {22'd0, s_sum}, {22'd0, m_sum_s});
    check("u_out_valid", {31'd0, u_valid}, {31'd0, m_valid});
    check("u_out_d", {24'd0, u_d}, m_lane[3]);
    check("u_out_sum", {22'd0, u_sum}, {22'd0, m_sum_u});
  endtask

  // One clock: drive inputs, check in_ready before the edge, advance model, check after.
  task automatic cycle(input bit v, input int d, input bit ab, input bit ordy);
    bit rdy, take, loaded;
    in_valid  = v;
    in_data   = d[7:0];
    in_abort  = ab;
    out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    check("in_ready", {31'd0, s_in_ready}, {31'd0, rdy});
    check("u_in_ready", {31'd0, u_in_ready}, {31'd0, rdy});
    @(posedge clk);
    take   = m_valid && ordy;
    loaded = 1'b0;
    if (ab) begin
      beats.delete();
    end else if (v && rdy) begin
      beats.push_back(d & 255);
      if (beats.size() == 4) begin
        for (int i = 0; i < 4; i++) m_lane[i] = beats[i];
        m_sum_s = ref_sum(4'b1110);
        m_sum_u = ref_sum(4'b0000);
        m_valid = 1'b1;
        loaded  = 1'b1;
        beats.delete();
      end
    end
    if (!loaded && take) m_valid = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic send_word(input int b0, input int b1, input int b2, input int b3,
                           input bit ordy);
    cycle(1'b1, b0, 1'b0, ordy);
    cycle(1'b1, b1, 1'b0, ordy);
    cycle(1'b1, b2, 1'b0, ordy);
    cycle(1'b1, b3, 1'b0, ordy);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_abort  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Mixed-sign word; explicit sums from hand arithmetic
    send_word(8'hFF, 8'h80, 8'h7F, 8'h01, 1'b1);
    check("w1_valid", {31'd0, s_valid}, 32'd1);
    check("w1_sum", {22'd0, s_sum}, 32'h0FF);
    check("w1_sum_u", {22'd0, u_sum}, 32'd511);
    cycle(1'b0, 0, 1'b0, 1'b1);

    send_word(8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    check("w2_sum", {22'd0, s_sum}, 32'h3FD);

    send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    check("w3_sum_u", {22'd0, u_sum}, 32'h3FC);
    check("w3_sum", {22'd0, s_sum}, 32'h0FC);

    // Stall: consumer not ready, beats must be refused and the word held
    send_word(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    check("stall_hold_a", {24'd0, s_a}, 32'hFF);
    send_word(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    check("after_stall_a", {24'd0, s_a}, 32'h11);
    check("after_stall_valid", {31'd0, s_valid}, 32'd1);

    // Abort after two beats, then a fresh word
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    cycle(1'b1, 8'hBB, 1'b0, 1'b1);
    cycle(1'b1, 8'hCC, 1'b1, 1'b1);
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    check("abort_a", {24'd0, s_a}, 32'h01);
    check("abort_d", {24'd0, s_d}, 32'h04);
    check("abort_sum", {22'd0, s_sum}, 32'h00A);

    // Asynchronous reset between beat 2 and beat 3
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_word(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    check("post_rst_sum", {22'd0, s_sum}, 32'h0A0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 255),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
